// File: rtl/memoria_rom.sv
// Instruction ROM for the fetch stage: fixed 128x32 program image, one registered read port.
// Read data appears one clock after the address is sampled; reset clears the output asynchronously.
module memoria_rom #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] douta
);

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic [DATA_WIDTH-1:0] rom_word_c;
    logic [DATA_WIDTH-1:0] douta_d;
    logic [DATA_WIDTH-1:0] douta_q;

    // Program image; every address above the last instruction holds a NOP.
    always_comb begin
        rom_word_c = DATA_WIDTH'(NOP_WORD);
        case (addra)
            ADDR_WIDTH'(0):  rom_word_c = DATA_WIDTH'(32'h00500093);
            ADDR_WIDTH'(1):  rom_word_c = DATA_WIDTH'(32'h00300113);
            ADDR_WIDTH'(2):  rom_word_c = DATA_WIDTH'(32'h002081B3);
            ADDR_WIDTH'(3):  rom_word_c = DATA_WIDTH'(32'h40208233);
            ADDR_WIDTH'(4):  rom_word_c = DATA_WIDTH'(32'h0020F2B3);
            ADDR_WIDTH'(5):  rom_word_c = DATA_WIDTH'(32'h0020E333);
            ADDR_WIDTH'(6):  rom_word_c = DATA_WIDTH'(32'h0020C3B3);
            ADDR_WIDTH'(7):  rom_word_c = DATA_WIDTH'(32'h00302023);
            ADDR_WIDTH'(8):  rom_word_c = DATA_WIDTH'(32'h00002403);
            ADDR_WIDTH'(9):  rom_word_c = DATA_WIDTH'(32'h00840463);
            ADDR_WIDTH'(10): rom_word_c = DATA_WIDTH'(32'h00100493);
            ADDR_WIDTH'(11): rom_word_c = DATA_WIDTH'(32'h00200513);
            ADDR_WIDTH'(12): rom_word_c = DATA_WIDTH'(32'h00A485B3);
            ADDR_WIDTH'(13): rom_word_c = DATA_WIDTH'(32'h00000013);
            ADDR_WIDTH'(14): rom_word_c = DATA_WIDTH'(32'h00000013);
            ADDR_WIDTH'(15): rom_word_c = DATA_WIDTH'(32'h0000006F);
            default:         rom_word_c = DATA_WIDTH'(NOP_WORD);
        endcase
    end

    always_comb begin
        douta_d = rom_word_c;
    end

    // Output register: cleared immediately on reset, loads a new word every edge otherwise.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            douta_q <= '0;
        end else begin
            douta_q <= douta_d;
        end
    end

    assign douta = douta_q;

endmodule

// File: tb/tb_memoria_rom.sv
// Directed bench for memoria_rom: reset hold/release, sweep, latency, fill region, mid-run reset.
module tb_memoria_rom;

    localparam int unsigned ADDR_WIDTH = 7;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [31:0] NOP_WORD   = 32'h00000013;

    logic                  clka;
    logic                  rsta;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] douta;

    int n_vec;
    int n_err;

    logic [31:0] prog [0:15];

    memoria_rom #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dut (
        .clka (clka),
        .rsta (rsta),
        .addra(addra),
        .douta(douta)
    );

    initial begin
        clka = 1'b0;
        forever #10 clka = ~clka;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, got %0d vectors, required completion", n_vec);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: douta=%08h expected=%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        if (a < 16) return prog[a];
        return NOP_WORD;
    endfunction

    // Apply an address mid-cycle, then sample one step after the following rising edge.
    task automatic read_at(input int a, input string tag);
        @(negedge clka);
        addra = ADDR_WIDTH'(a);
        @(posedge clka);
        #1;
        check(tag, douta, exp_word(a));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        prog[0]  = 32'h00500093; prog[1]  = 32'h00300113;
        prog[2]  = 32'h002081B3; prog[3]  = 32'h40208233;
        prog[4]  = 32'h0020F2B3; prog[5]  = 32'h0020E333;
        prog[6]  = 32'h0020C3B3; prog[7]  = 32'h00302023;
        prog[8]  = 32'h00002403; prog[9]  = 32'h00840463;
        prog[10] = 32'h00100493; prog[11] = 32'h00200513;
        prog[12] = 32'h00A485B3; prog[13] = 32'h00000013;
        prog[14] = 32'h00000013; prog[15] = 32'h0000006F;

        rsta  = 1'b1;
        addra = '0;

        // Reset hold for two edges
        for (int i = 0; i < 2; i++) begin
            @(posedge clka);
            #1;
            check("rst_hold", douta, 32'h0);
        end

        // Release 10 ns after an edge: no change until next rising edge
        @(negedge clka);
        rsta = 1'b0;
        #1;
        check("rel_hold", douta, 32'h0);
        @(posedge clka);
        #1;
        check("rel_first", douta, 32'h00500093);

        // Asynchronous clear mid-cycle after a nonzero read
        #4;
        rsta = 1'b1;
        #1;
        check("async_clr", douta, 32'h0);
        @(negedge clka);
        rsta = 1'b0;

        // Sequential sweep 0..16 with a mid-run reset pulse at address 5
        for (int a = 0; a <= 16; a++) begin
            @(negedge clka);
            addra = ADDR_WIDTH'(a);
            if (a == 5) begin
                #1;
                rsta = 1'b1;
                #1;
                check("midrun_clr", douta, 32'h0);
                #6;
                rsta = 1'b0;
                #1;
                check("midrun_rel", douta, 32'h0);
            end
            @(posedge clka);
            #1;
            check($sformatf("sweep_%0d", a), douta, exp_word(a));
        end

        // Latency: address change between edges has no effect until the next edge
        read_at(2, "lat_a2");
        #3;
        addra = ADDR_WIDTH'(3);
        #1;
        check("lat_hold", douta, 32'h002081B3);
        @(negedge clka);
        #1;
        check("lat_hold2", douta, 32'h002081B3);
        @(posedge clka);
        #1;
        check("lat_a3", douta, 32'h40208233);

        // Fill region and top address, then back into the program
        read_at(127, "top_127");
        read_at(64, "fill_64");
        read_at(9, "back_9");

        // Same address held stays constant
        @(posedge clka);
        #1;
        check("hold_9", douta, 32'h00840463);

        // Back-to-back non-sequential reads
        read_at(15, "b2b_15");
        read_at(12, "b2b_12");
        read_at(0, "b2b_0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
